// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin slot arbiter sharing one down-counter; macro TIMER_ARB_PRIO_EN gives requester 0 priority
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    output logic [NREQ-1:0]    gnt,
    output logic [CW-1:0]      count,
    output logic [NREQ-1:0]    done,
    output logic               busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic [CW-1:0]   count_nxt;

    logic [PW-1:0]   win;
    logic            win_vld;
    logic [PW-1:0]   ptr_adv;
    logic            ptr_upd;

    // Round-robin search: first requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        idx_p   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_p = PW'(idx);
`ifdef TIMER_ARB_PRIO_EN
            if (!win_vld && req[idx_p] && (idx_p != '0)) begin
`else
            if (!win_vld && req[idx_p]) begin
`endif
                win     = idx_p;
                win_vld = 1'b1;
            end
        end
`ifdef TIMER_ARB_PRIO_EN
        // Requester 0 overrides the rotation whenever it asks
        if (req[0]) begin
            win     = '0;
            win_vld = 1'b1;
        end
`endif
    end

    // Pointer moves past the finishing owner; a requester-0 priority slot leaves it alone
    always_comb begin
        ptr_adv = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
`ifdef TIMER_ARB_PRIO_EN
        ptr_upd = (owner != '0);
`else
        ptr_upd = 1'b1;
`endif
    end

    // Next-state and datapath: load on grant, count down while owner holds req, abort on drop
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        count_nxt = count;
        done_nxt  = '0;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        case (state)
            IDLE: begin
                gnt_nxt   = '0;
                count_nxt = '0;
                if (win_vld) begin
                    state_nxt      = RUN;
                    owner_nxt      = win;
                    count_nxt      = dur[int'(win)*CW +: CW];
                    gnt_nxt[win]   = 1'b1;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_nxt = DONE;
                    gnt_nxt   = '0;
                    count_nxt = '0;
                    if (ptr_upd) begin
                        ptr_nxt = ptr_adv;
                    end
                end else if (count != '0) begin
                    count_nxt = count - CW'(1);
                end else begin
                    state_nxt       = DONE;
                    gnt_nxt         = '0;
                    done_nxt[owner] = 1'b1;
                    if (ptr_upd) begin
                        ptr_nxt = ptr_adv;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                count_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                count_nxt = '0;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately, even mid-slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            count <= '0;
            done  <= '0;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            count <= count_nxt;
            done  <= done_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
